// File: rtl/tube_event_readout_pkg.sv
// Shared definitions for the tube event readout: FSM encoding, output-word
// field layout and the parameter legality check.
package tube_event_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_SNAP   = 2'd2,
    ST_SEND   = 2'd3
  } state_t;

  // Output word is {hit, idx, count} with count in the least significant bits.
  localparam int CNT_LSB = 32'sd0;

  function automatic int f_idx_lsb(input int cnt_w);
    return CNT_LSB + cnt_w;
  endfunction

  function automatic int f_hit_bit(input int idx_w, input int cnt_w);
    return f_idx_lsb(cnt_w) + idx_w;
  endfunction

  function automatic bit f_params_ok(input int num_tubes, input int idx_w,
                                     input int cnt_w, input int window);
    return (num_tubes >= 32'sd1) &&
           ((32'sd1 << idx_w) >= num_tubes) &&
           (window >= 32'sd1) &&
           (window <= ((32'sd1 << cnt_w) - 32'sd1));
  endfunction

endpackage

// File: rtl/tube_event_readout_if.sv
// Valid/ready word stream from the readout block to the host link.
interface tube_event_readout_if #(
  parameter int DATA_W = 12
);
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/tube_event_readout.sv
// Trigger-driven gate window over NUM_TUBES tube counters: open the gate, freeze
// the counts into a shadow register, then stream one {hit, idx, count} word per tube.
module tube_event_readout
  import tube_event_readout_pkg::*;
#(
  parameter int NUM_TUBES = 8,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = 3,
  parameter int WINDOW    = 200
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       trigger,
  input  logic [NUM_TUBES*CNT_W-1:0] tube_data,
  output logic                       tube_clr,
  output logic                       gate_enable,
  output logic                       busy,
  output logic                       trig_dropped,
  tube_event_readout_if.master       out_if
);

  localparam int DATA_W  = 1 + IDX_W + CNT_W;
  localparam int IDX_LSB = f_idx_lsb(CNT_W);
  localparam int HIT_BIT = f_hit_bit(IDX_W, CNT_W);

  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TUBES - 1);

  if (!f_params_ok(NUM_TUBES, IDX_W, CNT_W, WINDOW)) begin : g_param_check
    $error("tube_event_readout: illegal NUM_TUBES/IDX_W/CNT_W/WINDOW combination");
  end

  function automatic logic [DATA_W-1:0] f_word(input logic [IDX_W-1:0] idx,
                                               input logic [CNT_W-1:0] cnt);
    logic [DATA_W-1:0] w;
    w                   = '0;
    w[HIT_BIT]          = (cnt < WIN_CNT);
    w[IDX_LSB +: IDX_W] = idx;
    w[CNT_LSB +: CNT_W] = cnt;
    return w;
  endfunction

  state_t                             r_state, w_state_nxt;
  logic [CNT_W-1:0]                   r_timer, w_timer_nxt;
  logic [IDX_W-1:0]                   r_idx, w_idx_nxt, w_idx_inc;
  logic [NUM_TUBES-1:0][CNT_W-1:0]    r_shadow, w_shadow_nxt, w_tube;
  logic                               r_valid, w_valid_nxt;
  logic                               r_last, w_last_nxt;
  logic [DATA_W-1:0]                  r_data, w_data_nxt;
  logic                               r_clr, w_clr_nxt;
  logic                               r_gate, w_gate_nxt;
  logic                               r_drop, w_drop_nxt;

  assign w_tube    = tube_data;
  assign w_idx_inc = r_idx + IDX_ONE;

  // Next-state and next-output logic; every register's next value defaults to hold.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_valid_nxt  = r_valid;
    w_last_nxt   = r_last;
    w_data_nxt   = r_data;
    w_clr_nxt    = r_clr;
    w_gate_nxt   = r_gate;

    if (trigger && (r_state != ST_IDLE)) begin
      w_drop_nxt = 1'b1;
    end else begin
      w_drop_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        w_clr_nxt  = 1'b1;
        w_gate_nxt = 1'b0;
        if (trigger) begin
          w_state_nxt = ST_WINDOW;
          w_timer_nxt = '0;
          w_clr_nxt   = 1'b0;
          w_gate_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WINDOW: begin
        if (r_timer == WIN_LAST) begin
          w_state_nxt = ST_SNAP;
          w_gate_nxt  = 1'b0;
        end else begin
          w_timer_nxt = r_timer + CNT_ONE;
        end
      end
      ST_SNAP: begin
        // The shadow is not loaded yet, so word 0 is built from the live counts.
        w_shadow_nxt = w_tube;
        w_clr_nxt    = 1'b1;
        w_state_nxt  = ST_SEND;
        w_idx_nxt    = '0;
        w_valid_nxt  = 1'b1;
        w_data_nxt   = f_word('0, w_tube[0]);
        w_last_nxt   = (LAST_IDX == '0);
      end
      ST_SEND: begin
        if (r_valid && out_if.out_ready) begin
          if (r_last) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_data_nxt  = '0;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_data_nxt = f_word(w_idx_inc, r_shadow[w_idx_inc]);
            w_last_nxt = (w_idx_inc == LAST_IDX);
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_clr_nxt   = 1'b1;
        w_gate_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the tubes in clear with the gate shut.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
      r_clr    <= 1'b1;
      r_gate   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_valid  <= w_valid_nxt;
      r_last   <= w_last_nxt;
      r_data   <= w_data_nxt;
      r_clr    <= w_clr_nxt;
      r_gate   <= w_gate_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  assign tube_clr         = r_clr;
  assign gate_enable      = r_gate;
  assign busy             = (r_state != ST_IDLE);
  assign trig_dropped     = r_drop;
  assign out_if.out_valid = r_valid;
  assign out_if.out_last  = r_last;
  assign out_if.out_data  = r_data;

endmodule
